// File: rtl/splitmix64_seed_expander_pkg.sv
// Shared constants and state encoding for the SplitMix64 seed expander.
//   SPLITMIX_GAMMA : state increment added once per output word
//   SPLITMIX_C1/C2 : finaliser multipliers
//   sm_state_e     : 3-bit FSM encoding used by the expander
//   xorshr()       : v ^ (v >> sh), the logical xor-shift step of the finaliser
package splitmix64_seed_expander_pkg;

  localparam logic [63:0] SPLITMIX_GAMMA = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] SPLITMIX_C1    = 64'hBF58476D1CE4E5B9;
  localparam logic [63:0] SPLITMIX_C2    = 64'h94D049BB133111EB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAMMA = 3'd1,
    ST_MUL1  = 3'd2,
    ST_MUL2  = 3'd3,
    ST_VALID = 3'd4
  } sm_state_e;

  function automatic logic [63:0] xorshr(input logic [63:0] v, input int unsigned sh);
    return v ^ (v >> sh);
  endfunction

endpackage

// File: rtl/splitmix64_seed_expander_if.sv
// Request/response bundle between a seed consumer and the expander.
//   start, seed_in : expansion request (driven by master)
//   busy           : expansion in progress (driven by slave)
//   seed_valid     : seed_out complete (driven by slave)
//   seed_ready     : consumer accepts seed_out (driven by master)
//   seed_out       : expanded seed, word k at [64k+63:64k] (driven by slave)
interface splitmix64_seed_expander_if #(
  parameter int NUM_WORDS = 4
);
  logic                     start;
  logic [63:0]              seed_in;
  logic                     busy;
  logic                     seed_valid;
  logic                     seed_ready;
  logic [64*NUM_WORDS-1:0]  seed_out;

  modport master (output start, seed_in, seed_ready,
                  input  busy, seed_valid, seed_out);
  modport slave  (input  start, seed_in, seed_ready,
                  output busy, seed_valid, seed_out);
endinterface

// File: rtl/splitmix64_seed_expander_mul64_lo.sv
// Combinational 64x64 multiplier returning only the low 64 bits of the product.
//   a_i, b_i : unsigned operands
//   p_o      : (a_i * b_i) mod 2^64
module splitmix64_seed_expander_mul64_lo (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/splitmix64_seed_expander.sv
// Expands one 64-bit seed into NUM_WORDS SplitMix64 words, three clocks per word.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   ctrl_if : slave side of the request/response bundle
//
// state | meaning
// IDLE  | waiting for start; seed_out holds the last result
// GAMMA | advance st by GAMMA, first xor-shift into z
// MUL1  | z = xorshr(z*C1, 27)
// MUL2  | word[idx] = xorshr(z*C2, 31), idx++
// VALID | seed_out complete, wait for seed_ready
module splitmix64_seed_expander
  import splitmix64_seed_expander_pkg::*;
#(
  parameter int          NUM_WORDS = 4,
  parameter logic [63:0] GAMMA     = SPLITMIX_GAMMA,
  parameter logic [63:0] MIX_C1    = SPLITMIX_C1,
  parameter logic [63:0] MIX_C2    = SPLITMIX_C2
) (
  input  logic clk,
  input  logic rst,
  splitmix64_seed_expander_if.slave ctrl_if
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int OUT_W = 64 * NUM_WORDS;

  sm_state_e          state_q, state_d;
  logic [63:0]        st_q, st_d;
  logic [63:0]        z_q, z_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_q, out_d;

  logic [63:0]        x_sum;
  logic [63:0]        mul_b;
  logic [63:0]        mul_p;
  logic [63:0]        word;

  // One shared multiplier; only the constant operand changes between MUL1 and MUL2.
  assign mul_b = (state_q == ST_MUL2) ? MIX_C2 : MIX_C1;

  splitmix64_seed_expander_mul64_lo u_mul (
    .a_i (z_q),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign x_sum = st_q + GAMMA;
  assign word  = xorshr(mul_p, 31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      z_q     <= z_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    z_d     = z_q;
    idx_d   = idx_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_if.start) begin
          st_d    = ctrl_if.seed_in;
          idx_d   = '0;
          state_d = ST_GAMMA;
        end
      end
      ST_GAMMA: begin
        st_d    = x_sum;
        z_d     = xorshr(x_sum, 30);
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        z_d     = xorshr(mul_p, 27);
        state_d = ST_MUL2;
      end
      ST_MUL2: begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (idx_q == IDX_W'(k)) out_d[64*k +: 64] = word;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
          // Never hand an all-zero state to the xorshift generator.
          if (out_d == '0) out_d[0] = 1'b1;
          state_d = ST_VALID;
        end else begin
          state_d = ST_GAMMA;
        end
      end
      ST_VALID: begin
        if (ctrl_if.seed_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ctrl_if.busy       = (state_q == ST_GAMMA) || (state_q == ST_MUL1) || (state_q == ST_MUL2);
  assign ctrl_if.seed_valid = (state_q == ST_VALID);
  assign ctrl_if.seed_out   = out_q;

endmodule

// File: tb/tb_splitmix64_seed_expander.sv
module tb_splitmix64_seed_expander;

  localparam logic [255:0] SEED0_EXP = {64'hF88BB8A8724C81EC, 64'h06C45D188009454F,
                                        64'h6E789E6AA1B965F4, 64'hE220A8397B1DCDAF};

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [255:0] exp_q[$];

  splitmix64_seed_expander_if #(.NUM_WORDS(4)) sif ();

  splitmix64_seed_expander #(.NUM_WORDS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Straight-line SplitMix64 reference, as in the published C code.
  function automatic logic [255:0] sm_ref(input logic [63:0] seed);
    logic [255:0] r;
    logic [63:0]  s, z;
    s = seed;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = s + 64'h9E3779B97F4A7C15;
      z = s;
      z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
      z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
      z = z ^ (z >> 31);
      r[64*k +: 64] = z;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted seed is compared with the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sif.seed_valid && sif.seed_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_seed: got %h expected no seed", sif.seed_out);
        end else begin
          check("seed_out", sif.seed_out, exp_q.pop_front());
        end
      end
    end
  end

  // Issue a request; returns #1 after the edge where seed_valid rises.
  task automatic expand(input logic [63:0] seed, input logic [255:0] exp,
                        input bit hold_start, input string tag);
    int cyc;
    int busy_cnt;
    sif.start   = 1'b1;
    sif.seed_in = seed;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (!hold_start) sif.start = 1'b0;
    cyc      = 0;
    busy_cnt = sif.busy ? 1 : 0;
    while (!sif.seed_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (sif.busy) busy_cnt++;
    end
    sif.start = 1'b0;
    check({tag, "_latency"}, 256'(cyc), 256'(12));
    check({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(12));
  endtask

  task automatic accept(input string tag);
    sif.seed_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_after_accept"}, 256'(sif.seed_valid), 256'(0));
  endtask

  initial begin
    int bad;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    sif.start      = 1'b0;
    sif.seed_in    = '0;
    sif.seed_ready = 1'b1;
    #23;
    check("reset_busy",  256'(sif.busy),       256'(0));
    check("reset_valid", 256'(sif.seed_valid), 256'(0));
    check("reset_out",   sif.seed_out,         256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: seed 0 against the published vector
    expand(64'h0, SEED0_EXP, 1'b0, "s1");
    accept("s1");

    // 2: all-ones seed wraps st on the first add
    expand(64'hFFFF_FFFF_FFFF_FFFF, sm_ref(64'hFFFF_FFFF_FFFF_FFFF), 1'b0, "s2");
    accept("s2");

    // 3: backpressure, start during VALID is ignored
    sif.seed_ready = 1'b0;
    expand(64'h0123_4567_89AB_CDEF, sm_ref(64'h0123_4567_89AB_CDEF), 1'b0, "s3");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        sif.start   = 1'b1;
        sif.seed_in = 64'hDEAD_BEEF_0000_0001;
      end else begin
        sif.start = 1'b0;
      end
      @(posedge clk); #1;
      if (sif.seed_valid !== 1'b1 || sif.seed_out !== sm_ref(64'h0123_4567_89AB_CDEF)) bad++;
    end
    sif.start = 1'b0;
    check("s3_hold_stable", 256'(bad), 256'(0));
    accept("s3");
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (sif.busy !== 1'b0 || sif.seed_valid !== 1'b0) bad++;
    end
    check("s3_no_queued_start", 256'(bad), 256'(0));

    // 4: start held every cycle still gives exactly one expansion
    expand(64'h0, SEED0_EXP, 1'b1, "s4");
    accept("s4");
    @(posedge clk); #1;
    check("s4_single_run", 256'(sif.busy), 256'(0));

    // 5: reset in the middle of an expansion
    sif.start   = 1'b1;
    sif.seed_in = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("s5_abort_busy",  256'(sif.busy),       256'(0));
    check("s5_abort_valid", 256'(sif.seed_valid), 256'(0));
    check("s5_abort_out",   sif.seed_out,         256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("s5_idle_after_rst", 256'({sif.busy, sif.seed_valid}), 256'(0));
    expand(64'h0, SEED0_EXP, 1'b0, "s5");
    accept("s5");

    // 6: back-to-back, new start right after acceptance
    expand(64'h1, sm_ref(64'h1), 1'b0, "s6");
    accept("s6");

    repeat (3) @(posedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
